// File: rtl/range_ctrl_pkg.sv
// range_ctrl_pkg: shared state encoding and default range for the range counter controller
package range_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} state_e;
    localparam int RC_W         = 8;
    localparam int RC_DEF_START = 5;
    localparam int RC_DEF_END   = 67;
endpackage

// File: rtl/range_count_ctrl_if.sv
// range_count_ctrl_if: configuration handshake, run controls and status of the range counter
interface range_count_ctrl_if import range_ctrl_pkg::*; #(parameter int W = RC_W);
    logic         cfg_valid, cfg_ready;
    logic [W-1:0] cfg_start, cfg_end;
    logic         go, pause, abort;
    logic [W-1:0] count;
    logic         busy, done, cfg_err;
    modport master (output cfg_valid, cfg_start, cfg_end, go, pause, abort,
                    input cfg_ready, count, busy, done, cfg_err);
    modport slave  (input cfg_valid, cfg_start, cfg_end, go, pause, abort,
                    output cfg_ready, count, busy, done, cfg_err);
endinterface

// File: rtl/range_ctrl_counter.sv
// range_ctrl_counter: W-bit up-counter with load/inc/hold controls and end-of-range compare
module range_ctrl_counter #(
    parameter int W       = 8,
    parameter int RST_VAL = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         inc,
    input  logic [W-1:0] load_val,
    input  logic [W-1:0] end_val,
    output logic [W-1:0] count,
    output logic         eq_end
);
    logic [W-1:0] count_q, count_d;
    always_comb count_d = load ? load_val : inc ? count_q + 1'b1 : count_q;
    always_ff @(posedge clk) count_q <= !rst_n ? W'(RST_VAL) : count_d;
    assign count  = count_q;
    assign eq_end = count_q == end_val;
endmodule

// File: rtl/range_count_ctrl.sv
// range_count_ctrl: range counter sequencer; RANGE_CTRL_AUTORELOAD_EN makes runs wrap to start instead of stopping
module range_count_ctrl import range_ctrl_pkg::*; #(
    parameter int W         = RC_W,
    parameter int DEF_START = RC_DEF_START,
    parameter int DEF_END   = RC_DEF_END
) (
    input logic               clk,
    input logic               rst_n,
    range_count_ctrl_if.slave bus
);
    state_e       state_q, state_d;
    logic [W-1:0] start_q, start_d, end_q, end_d, load_val;
    logic         done_q, done_d, err_q, err_d, load, inc, eq_end;
    range_ctrl_counter #(.W(W), .RST_VAL(DEF_START)) u_cnt (
        .clk(clk), .rst_n(rst_n), .load(load), .inc(inc), .load_val(load_val),
        .end_val(end_q), .count(bus.count), .eq_end(eq_end)
    );
    // a config accept overrides whatever the current state would do this cycle
    always_comb begin
        state_d  = state_q;
        start_d  = start_q;
        end_d    = end_q;
        load     = 1'b0;
        inc      = 1'b0;
        load_val = start_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        if (bus.cfg_valid && state_q != RUN) begin
            if (bus.cfg_start > bus.cfg_end) begin
                err_d   = 1'b1;
                state_d = IDLE;
            end else begin
                start_d  = bus.cfg_start;
                end_d    = bus.cfg_end;
                load     = 1'b1;
                load_val = bus.cfg_start;
                state_d  = ARMED;
            end
        end else begin
            case (state_q)
                ARMED: state_d = bus.abort ? IDLE : bus.go ? RUN : ARMED;
                RUN: begin
                    if (bus.abort) state_d = IDLE;
                    else if (!bus.pause) begin
                        if (eq_end) begin
                            done_d = 1'b1;
`ifdef RANGE_CTRL_AUTORELOAD_EN
                            load = 1'b1;
`else
                            state_d = DONE;
`endif
                        end else inc = 1'b1;
                    end
                end
                DONE: begin
                    if (bus.abort) state_d = IDLE;
                    else if (bus.go) begin
                        load    = 1'b1;
                        state_d = RUN;
                    end
                end
                default: ;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ARMED;
            start_q <= W'(DEF_START);
            end_q   <= W'(DEF_END);
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            end_q   <= end_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end
    assign bus.cfg_ready = state_q != RUN;
    assign bus.busy      = state_q == RUN;
    assign bus.done      = done_q;
    assign bus.cfg_err   = err_q;
endmodule

// File: tb/tb_range_count_ctrl.sv
// tb_range_count_ctrl: directed self-checking bench for range_count_ctrl
module tb_range_count_ctrl;
    logic clk = 1'b0, rst_n = 1'b0;
    int errors = 0, checks = 0;
    range_count_ctrl_if #(.W(8)) bus();
    range_count_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    always #5 clk = ~clk;
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask
    task automatic cfg(input logic [7:0] s, input logic [7:0] e);
        bus.cfg_valid = 1'b1;
        bus.cfg_start = s;
        bus.cfg_end = e;
        step();
        bus.cfg_valid = 1'b0;
    endtask
    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++; if (bus.count !== 8'd5) begin errors++; $display("FAIL reset_count got=%0d exp=5", bus.count); end
        checks++; if ({bus.busy, bus.done, bus.cfg_err, bus.cfg_ready} !== 4'b0001) begin errors++; $display("FAIL reset_flags got=%b exp=0001", {bus.busy, bus.done, bus.cfg_err, bus.cfg_ready}); end
        rst_n = 1'b1;
    endtask
    task automatic test_default_run();
        bus.go = 1'b1;
        step();
        bus.go = 1'b0;
        checks++; if (bus.count !== 8'd5 || bus.busy !== 1'b1) begin errors++; $display("FAIL def_go count=%0d busy=%b exp 5/1", bus.count, bus.busy); end
        for (int k = 1; k <= 62; k++) begin
            step();
            checks++; if (bus.count !== 8'(5 + k) || bus.done !== 1'b0) begin errors++; $display("FAIL def_walk k=%0d count=%0d done=%b exp %0d/0", k, bus.count, bus.done, 5 + k); end
        end
        step();
        checks++; if (bus.done !== 1'b1 || bus.count !== 8'd67 || bus.busy !== 1'b0) begin errors++; $display("FAIL def_done done=%b count=%0d busy=%b exp 1/67/0", bus.done, bus.count, bus.busy); end
        step();
        checks++; if (bus.done !== 1'b0 || bus.count !== 8'd67) begin errors++; $display("FAIL def_hold done=%b count=%0d exp 0/67", bus.done, bus.count); end
    endtask
    task automatic test_cfg_run();
        cfg(8'd10, 8'd12);
        checks++; if (bus.count !== 8'd10 || bus.cfg_err !== 1'b0 || bus.cfg_ready !== 1'b1) begin errors++; $display("FAIL cfg_load count=%0d err=%b rdy=%b exp 10/0/1", bus.count, bus.cfg_err, bus.cfg_ready); end
        for (int r = 0; r < 2; r++) begin
            bus.go = 1'b1;
            step();
            bus.go = 1'b0;
            checks++; if (bus.count !== 8'd10 || bus.busy !== 1'b1 || bus.cfg_ready !== 1'b0) begin errors++; $display("FAIL cfg_go r=%0d count=%0d busy=%b rdy=%b exp 10/1/0", r, bus.count, bus.busy, bus.cfg_ready); end
            step();
            checks++; if (bus.count !== 8'd11) begin errors++; $display("FAIL cfg_11 r=%0d got=%0d exp=11", r, bus.count); end
            step();
            checks++; if (bus.count !== 8'd12 || bus.done !== 1'b0) begin errors++; $display("FAIL cfg_12 r=%0d count=%0d done=%b exp 12/0", r, bus.count, bus.done); end
            step();
            checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.count !== 8'd12) begin errors++; $display("FAIL cfg_done r=%0d done=%b busy=%b count=%0d exp 1/0/12", r, bus.done, bus.busy, bus.count); end
        end
    endtask
    task automatic test_cfg_err();
        cfg(8'd20, 8'd3);
        checks++; if (bus.cfg_err !== 1'b1 || bus.count !== 8'd12 || bus.cfg_ready !== 1'b1) begin errors++; $display("FAIL err_pulse err=%b count=%0d rdy=%b exp 1/12/1", bus.cfg_err, bus.count, bus.cfg_ready); end
        bus.go = 1'b1;
        step();
        checks++; if (bus.cfg_err !== 1'b0) begin errors++; $display("FAIL err_one got=%b exp=0", bus.cfg_err); end
        step();
        bus.go = 1'b0;
        checks++; if (bus.busy !== 1'b0 || bus.count !== 8'd12) begin errors++; $display("FAIL err_idle busy=%b count=%0d exp 0/12", bus.busy, bus.count); end
        cfg(8'd1, 8'd2);
        checks++; if (bus.count !== 8'd1 || bus.cfg_err !== 1'b0) begin errors++; $display("FAIL err_recover count=%0d err=%b exp 1/0", bus.count, bus.cfg_err); end
        bus.go = 1'b1;
        step();
        bus.go = 1'b0;
        step();
        checks++; if (bus.count !== 8'd2 || bus.busy !== 1'b1) begin errors++; $display("FAIL err_run count=%0d busy=%b exp 2/1", bus.count, bus.busy); end
        step();
        checks++; if (bus.done !== 1'b1 || bus.count !== 8'd2) begin errors++; $display("FAIL err_done done=%b count=%0d exp 1/2", bus.done, bus.count); end
    endtask
    task automatic test_pause();
        int n;
        do_reset();
        bus.go = 1'b1;
        step();
        bus.go = 1'b0;
        repeat (25) step();
        checks++; if (bus.count !== 8'd30) begin errors++; $display("FAIL pause_at got=%0d exp=30", bus.count); end
        bus.pause = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (bus.count !== 8'd30 || bus.busy !== 1'b1) begin errors++; $display("FAIL pause_hold i=%0d count=%0d busy=%b exp 30/1", i, bus.count, bus.busy); end
        end
        bus.pause = 1'b0;
        n = 29;
        while (bus.done !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        checks++; if (n !== 67 || bus.count !== 8'd67) begin errors++; $display("FAIL pause_delay edge=%0d count=%0d exp 67/67", n, bus.count); end
    endtask
    task automatic test_abort_reset();
        do_reset();
        bus.go = 1'b1;
        step();
        bus.go = 1'b0;
        repeat (35) step();
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        checks++; if (bus.busy !== 1'b0 || bus.count !== 8'd40 || bus.cfg_ready !== 1'b1 || bus.done !== 1'b0) begin errors++; $display("FAIL abort busy=%b count=%0d rdy=%b done=%b exp 0/40/1/0", bus.busy, bus.count, bus.cfg_ready, bus.done); end
        bus.go = 1'b1;
        step();
        step();
        bus.go = 1'b0;
        checks++; if (bus.busy !== 1'b0 || bus.count !== 8'd40) begin errors++; $display("FAIL abort_idle busy=%b count=%0d exp 0/40", bus.busy, bus.count); end
        do_reset();
        bus.go = 1'b1;
        step();
        bus.go = 1'b0;
        repeat (10) step();
        do_reset();
        checks++; if (bus.count !== 8'd5 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL midrst count=%0d busy=%b done=%b exp 5/0/0", bus.count, bus.busy, bus.done); end
        bus.go = 1'b1;
        step();
        bus.go = 1'b0;
        checks++; if (bus.count !== 8'd5 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin errors++; $display("FAIL midrst_armed count=%0d busy=%b done=%b exp 5/1/0", bus.count, bus.busy, bus.done); end
        step();
        checks++; if (bus.count !== 8'd6) begin errors++; $display("FAIL midrst_run got=%0d exp=6", bus.count); end
        do_reset();
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        bus.go = 1'b1;
        step();
        step();
        bus.go = 1'b0;
        checks++; if (bus.busy !== 1'b0 || bus.count !== 8'd5) begin errors++; $display("FAIL armed_abort busy=%b count=%0d exp 0/5", bus.busy, bus.count); end
    endtask
    task automatic test_boundary();
        cfg(8'd255, 8'd255);
        checks++; if (bus.count !== 8'd255 || bus.cfg_err !== 1'b0) begin errors++; $display("FAIL bnd_cfg count=%0d err=%b exp 255/0", bus.count, bus.cfg_err); end
        bus.go = 1'b1;
        step();
        bus.go = 1'b0;
        step();
        checks++; if (bus.done !== 1'b1 || bus.count !== 8'd255 || bus.busy !== 1'b0) begin errors++; $display("FAIL bnd_done done=%b count=%0d busy=%b exp 1/255/0", bus.done, bus.count, bus.busy); end
        step();
        checks++; if (bus.done !== 1'b0 || bus.count !== 8'd255) begin errors++; $display("FAIL bnd_hold done=%b count=%0d exp 0/255", bus.done, bus.count); end
    endtask
    task automatic test_autoreload();
        cfg(8'd0, 8'd2);
        bus.go = 1'b1;
        step();
        bus.go = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            step();
            checks++; if (bus.count !== 8'(k % 3) || bus.done !== (k % 3 == 0) || bus.busy !== 1'b1) begin errors++; $display("FAIL reload k=%0d count=%0d done=%b busy=%b exp %0d/%0d/1", k, bus.count, bus.done, bus.busy, k % 3, k % 3 == 0); end
        end
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reload_abort busy=%b exp 0", bus.busy); end
    endtask
    initial begin
        bus.cfg_valid = 1'b0;
        bus.cfg_start = '0;
        bus.cfg_end = '0;
        bus.go = 1'b0;
        bus.pause = 1'b0;
        bus.abort = 1'b0;
        test_reset();
`ifdef RANGE_CTRL_AUTORELOAD_EN
        test_autoreload();
`else
        test_default_run();
        test_cfg_run();
        test_cfg_err();
        test_pause();
        test_abort_reset();
        test_boundary();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
